// File: rtl/swap_fabric_sequencer_pkg.sv
// Shared types and defaults for the swap fabric sequencer and its swap cells.
package swap_fabric_sequencer_pkg;

    localparam int DEF_NUM_CELLS = 4;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_DWELL_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/swap_fabric_sequencer_cswap_cell.sv
// Single controlled-swap (Fredkin) cell: straight when sel=0, crossed when sel=1.
module cswap_cell (
    input  logic i_sel,
    input  logic i_a,
    input  logic i_b,
    output logic o_x,
    output logic o_y
);

    assign o_x = i_sel ? i_b : i_a;
    assign o_y = i_sel ? i_a : i_b;

endmodule

// File: rtl/swap_fabric_sequencer.sv
// Serially programmed step sequencer driving a bank of controlled-swap cells.
//  state | meaning
//  IDLE  | pass-through (sel=0), waiting for prog_en or start
//  LOAD  | shifting program bits in, one word per NUM_CELLS bits
//  RUN   | stepping through the program, dwell+1 cycles per step
module swap_fabric_sequencer
    import swap_fabric_sequencer_pkg::*;
#(
    parameter  int NUM_CELLS = DEF_NUM_CELLS,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int DWELL_W   = DEF_DWELL_W,
    localparam int SW        = idx_width(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_prog_en,
    input  logic                 i_prog_bit,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [DWELL_W-1:0]   i_dwell,
    input  logic [NUM_CELLS-1:0] i_data_a,
    input  logic [NUM_CELLS-1:0] i_data_b,
    output logic [NUM_CELLS-1:0] o_out_x,
    output logic [NUM_CELLS-1:0] o_out_y,
    output logic [NUM_CELLS-1:0] o_sel_out,
    output logic [SW-1:0]        o_step_idx,
    output logic                 o_busy,
    output logic                 o_wrap
);

    localparam int LW = SW + 1;
    localparam int BW = idx_width(NUM_CELLS);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_CELLS - 1);
    localparam logic [LW-1:0] FULL_LEN = LW'(DEPTH);

    seq_state_t             r_state;
    logic [NUM_CELLS-1:0]   r_mem [DEPTH];
    logic [LW-1:0]          r_len;
    logic [SW-1:0]          r_wr_ptr;
    logic [BW-1:0]          r_bit_cnt;
    logic [NUM_CELLS-1:0]   r_shift;
    logic [SW-1:0]          r_step;
    logic [DWELL_W-1:0]     r_dwell_cnt;
    logic [DWELL_W-1:0]     r_dwell_lat;
    logic                   r_wrap;
    logic [NUM_CELLS-1:0]   r_sel;
    logic [NUM_CELLS-1:0]   r_out_x;
    logic [NUM_CELLS-1:0]   r_out_y;

    seq_state_t             w_state_nxt;
    logic [LW-1:0]          w_len_nxt;
    logic [SW-1:0]          w_wr_ptr_nxt;
    logic [BW-1:0]          w_bit_cnt_nxt;
    logic [NUM_CELLS-1:0]   w_shift_nxt;
    logic [SW-1:0]          w_step_nxt;
    logic [DWELL_W-1:0]     w_dwell_cnt_nxt;
    logic [DWELL_W-1:0]     w_dwell_lat_nxt;
    logic                   w_wrap_nxt;
    logic [NUM_CELLS-1:0]   w_sel_nxt;
    logic                   w_ld_active;
    logic [BW-1:0]          w_ld_bit_cnt;
    logic [SW-1:0]          w_ld_wr_ptr;
    logic [LW-1:0]          w_ld_len;
    logic [NUM_CELLS-1:0]   w_ld_word;
    logic [SW-1:0]          w_last_step;
    logic                   w_mem_we;
    logic [SW-1:0]          w_mem_waddr;
    logic [NUM_CELLS-1:0]   w_mem_wdata;
    logic [NUM_CELLS-1:0]   w_x;
    logic [NUM_CELLS-1:0]   w_y;

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_step_nxt      = r_step;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_dwell_lat_nxt = r_dwell_lat;
        w_wrap_nxt      = 1'b0;
        w_ld_active     = 1'b0;
        w_ld_bit_cnt    = r_bit_cnt;
        w_ld_wr_ptr     = r_wr_ptr;
        w_ld_len        = r_len;
        w_ld_word       = r_shift;
        w_mem_we        = 1'b0;
        w_mem_waddr     = r_wr_ptr;
        w_mem_wdata     = r_shift;
        w_last_step     = SW'(r_len - 1'b1);

        case (r_state)
            IDLE: begin
                if (i_prog_en) begin
                    // A fresh load restarts the program; the bit on this edge is bit 0.
                    w_state_nxt  = LOAD;
                    w_ld_active  = 1'b1;
                    w_ld_bit_cnt = '0;
                    w_ld_wr_ptr  = '0;
                    w_ld_len     = '0;
                end else if (i_start && (r_len != '0)) begin
                    w_state_nxt     = RUN;
                    w_step_nxt      = '0;
                    w_dwell_cnt_nxt = '0;
                    w_dwell_lat_nxt = i_dwell;
                end
            end
            LOAD: begin
                if (i_prog_en) begin
                    w_ld_active = 1'b1;
                end else begin
                    w_state_nxt   = IDLE;
                    w_bit_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (i_stop) begin
                    w_state_nxt     = IDLE;
                    w_step_nxt      = '0;
                    w_dwell_cnt_nxt = '0;
                end else if (r_dwell_cnt == r_dwell_lat) begin
                    w_dwell_cnt_nxt = '0;
                    if (r_step == w_last_step) begin
                        w_step_nxt = '0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end else begin
                    w_dwell_cnt_nxt = r_dwell_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_ld_active) begin
            w_ld_word               = r_shift;
            w_ld_word[w_ld_bit_cnt] = i_prog_bit;
            w_shift_nxt             = w_ld_word;
            if (w_ld_bit_cnt == LAST_BIT) begin
                w_mem_we      = 1'b1;
                w_mem_waddr   = w_ld_wr_ptr;
                w_mem_wdata   = w_ld_word;
                w_wr_ptr_nxt  = w_ld_wr_ptr + 1'b1;
                w_len_nxt     = (w_ld_len == FULL_LEN) ? w_ld_len : w_ld_len + 1'b1;
                w_bit_cnt_nxt = '0;
            end else begin
                w_wr_ptr_nxt  = w_ld_wr_ptr;
                w_len_nxt     = w_ld_len;
                w_bit_cnt_nxt = w_ld_bit_cnt + 1'b1;
            end
        end

        // The datapath swaps with the select that lands in r_sel on this same edge.
        w_sel_nxt = (w_state_nxt == RUN) ? r_mem[w_step_nxt] : '0;
    end

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
        cswap_cell u_cell (
            .i_sel (w_sel_nxt[g]),
            .i_a   (i_data_a[g]),
            .i_b   (i_data_b[g]),
            .o_x   (w_x[g]),
            .o_y   (w_y[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_reset) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_step      <= '0;
            r_dwell_cnt <= '0;
            r_dwell_lat <= '0;
            r_wrap      <= 1'b0;
            r_sel       <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_step      <= w_step_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_dwell_lat <= w_dwell_lat_nxt;
            r_wrap      <= w_wrap_nxt;
            r_sel       <= w_sel_nxt;
            r_out_x     <= w_x;
            r_out_y     <= w_y;
        end
    end

    assign o_out_x    = r_out_x;
    assign o_out_y    = r_out_y;
    assign o_sel_out  = r_sel;
    assign o_step_idx = r_step;
    assign o_busy     = (r_state == RUN);
    assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_swap_fabric_sequencer.sv
// Scoreboarded bench for swap_fabric_sequencer: loads programs, runs them, checks every cycle.
module tb_swap_fabric_sequencer;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       prog_en  = 1'b0;
    logic       prog_bit = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic [2:0] dwell    = 3'd0;
    logic [3:0] data_a   = 4'd0;
    logic [3:0] data_b   = 4'd0;
    logic [3:0] out_x, out_y, sel_out;
    logic [2:0] step_idx;
    logic       busy, wrap;

    int n_vec = 0;
    int n_err = 0;
    logic [16:0] sb [$];

    wire [16:0] w_obs = {sel_out, step_idx, busy, wrap, out_x, out_y};

    always #5 clk = ~clk;

    swap_fabric_sequencer dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_prog_en  (prog_en),
        .i_prog_bit (prog_bit),
        .i_start    (start),
        .i_stop     (stop),
        .i_dwell    (dwell),
        .i_data_a   (data_a),
        .i_data_b   (data_b),
        .o_out_x    (out_x),
        .o_out_y    (out_y),
        .o_sel_out  (sel_out),
        .o_step_idx (step_idx),
        .o_busy     (busy),
        .o_wrap     (wrap)
    );

    // Expected {sel, idx, busy, wrap, x, y} for one cycle.
    function automatic logic [16:0] expected_outputs(input logic [3:0] sel, input logic [2:0] idx,
                                                     input logic bsy, input logic wr,
                                                     input logic [3:0] a, input logic [3:0] b);
        return {sel, idx, bsy, wr, (sel & b) | (~sel & a), (sel & a) | (~sel & b)};
    endfunction

    task automatic test_reset();
        logic [16:0] e;
        for (int i = 0; i < 3; i++) begin
            reset  = (i < 2);
            data_a = (i < 2) ? 4'(($urandom)) : 4'b1010;
            data_b = (i < 2) ? 4'(($urandom)) : 4'b0101;
            start  = 1'b1;
            sb.push_back((i < 2) ? 17'd0 : expected_outputs(4'd0, 3'd0, 1'b0, 1'b0, 4'b1010, 4'b0101));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (w_obs !== e) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %h want %h", i, w_obs, e);
            end
        end
        start = 1'b0;
    endtask

    // Shift nbits of the word list in LSB first, then drop prog_en for one cycle.
    task automatic test_load(input string name, input logic [3:0] words [16], input int nbits);
        logic [16:0] e;
        logic [3:0]  a, b, w;
        for (int i = 0; i <= nbits; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            w = words[i / 4];
            data_a   = a;
            data_b   = b;
            prog_en  = (i < nbits);
            prog_bit = (i < nbits) ? w[i % 4] : 1'b0;
            start    = (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop     = 1'($urandom_range(0, 1));
            sb.push_back(expected_outputs(4'd0, 3'd0, 1'b0, 1'b0, a, b));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (w_obs !== e) begin
                n_err++;
                $display("FAIL %s load cyc %0d: got %h want %h", name, i, w_obs, e);
            end
        end
        prog_en = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
    endtask

    // Start the loaded program, run n cycles, then stop (mode 0) or reset (mode 1).
    task automatic test_run(input string name, input logic [3:0] prog [8], input int len,
                            input int dw, input int n, input int mode, input bit fixed_ab);
        logic [16:0] e;
        logic [3:0]  a, b;
        int          st;
        logic        wr;
        for (int k = 0; k <= n; k++) begin
            a = fixed_ab ? 4'b1010 : 4'($urandom);
            b = fixed_ab ? 4'b0101 : 4'($urandom);
            data_a = a;
            data_b = b;
            if (k == 0) begin
                start   = 1'b1;
                dwell   = 3'(dw);
                prog_en = 1'b0;
                stop    = 1'b0;
            end else begin
                start   = 1'($urandom_range(0, 1));
                dwell   = 3'($urandom);
                prog_en = 1'($urandom_range(0, 1));
                stop    = (k == n) && (mode == 0);
                reset   = (k == n) && (mode == 1);
            end
            if (k < n) begin
                st = (k / (dw + 1)) % len;
                wr = (k > 0) && ((k % ((dw + 1) * len)) == 0);
                e  = expected_outputs(prog[st], 3'(st), 1'b1, wr, a, b);
            end else if (mode == 0) begin
                e = expected_outputs(4'd0, 3'd0, 1'b0, 1'b0, a, b);
            end else begin
                e = 17'd0;
            end
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (w_obs !== e) begin
                n_err++;
                $display("FAIL %s run k=%0d: got %h want %h", name, k, w_obs, e);
            end
        end
        start   = 1'b0;
        stop    = 1'b0;
        prog_en = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_start_len0();
        logic [16:0] e;
        logic [3:0]  a, b;
        for (int i = 0; i < 5; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            data_a = a;
            data_b = b;
            start  = 1'b1;
            dwell  = 3'($urandom);
            sb.push_back(expected_outputs(4'd0, 3'd0, 1'b0, 1'b0, a, b));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_vec++;
            if (w_obs !== e) begin
                n_err++;
                $display("FAIL start_len0 cyc %0d: got %h want %h", i, w_obs, e);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] words [16];
        logic [3:0] prog [8];

        test_reset();

        words = '{default: 4'd0};
        words[0] = 4'b0001;
        words[1] = 4'b1111;
        test_load("two_words", words, 8);
        prog = '{4'b0001, 4'b1111, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        test_run("dwell0", prog, 2, 0, 8, 0, 1'b1);
        test_run("dwell2_stop_mid", prog, 2, 2, 14, 0, 1'b0);
        test_run("stop_at_tc", prog, 2, 2, 9, 0, 1'b0);

        words[1] = 4'b0011;
        test_load("partial", words, 6);
        prog = '{default: 4'b0001};
        test_run("len1", prog, 1, 1, 8, 0, 1'b0);

        for (int i = 0; i < 9; i++) words[i] = 4'(i + 1);
        test_load("overflow", words, 36);
        prog = '{4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        test_run("overflow", prog, 8, 0, 18, 0, 1'b0);
        test_run("reset_mid", prog, 8, 3, 6, 1, 1'b0);

        test_start_len0();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/swap_fabric_sequencer.md
Name: swap_fabric_sequencer

Overview:
- Sequenced controller for a bank of controlled-swap (Fredkin) cells; each cell routes an (a,b) pair straight or crossed under its select bit.
- Holds a small program of per-cell select vectors, loaded serially over a pin-frugal 1-bit interface.
- Steps through the program in RUN, dwelling a programmable number of cycles per step.
- Sits behind the 12-pin user I/O wrapper and replaces static per-cell select pins with time-multiplexed configurations.

Parameters:
- NUM_CELLS, 4, number of swap cells; also the program word width in bits.
- DEPTH, 8, maximum program steps; must be a power of 2.
- DWELL_W, 3, width of the dwell input; each step lasts dwell+1 cycles.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- prog_en  in  1  high = serial load active.
- prog_bit  in  1  serial config bit; LSB (cell 0) first.
- start  in  1  level; begin RUN from IDLE.
- stop  in  1  level; abort RUN.
- dwell  in  DWELL_W  cycles-per-step minus 1; sampled on the start edge.
- data_a  in  NUM_CELLS  per-cell input a.
- data_b  in  NUM_CELLS  per-cell input b.
- out_x  out  NUM_CELLS  registered: sel ? b : a.
- out_y  out  NUM_CELLS  registered: sel ? a : b.
- sel_out  out  NUM_CELLS  registered select vector currently applied.
- step_idx  out  clog2(DEPTH)  program index currently applied.
- busy  out  1  high in RUN.
- wrap  out  1  one-cycle pulse when the step index returns from len-1 to 0.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE; all outputs 0; len=0; wr_ptr=0; bit_cnt=0; program memory contents don't-care.
  - Reset mid-LOAD or mid-RUN aborts immediately.
- States: IDLE, LOAD, RUN.
- IDLE:
  - prog_en=1 -> LOAD; wr_ptr=0, len=0, bit_cnt=0; the bit present on this edge is shifted in.
  - Else start=1 and len>0 -> RUN; step=0, dwell_cnt=0, dwell latched.
  - start with len=0 is ignored.
  - prog_en has priority over start.
- LOAD:
  - Each cycle with prog_en=1 shifts prog_bit into shift[bit_cnt].
  - When bit_cnt reaches NUM_CELLS-1, the assembled word is written to mem[wr_ptr]; wr_ptr increments modulo DEPTH; len=min(len+1,DEPTH); bit_cnt=0.
  - Past DEPTH words, wr_ptr wraps and overwrites from step 0; len stays DEPTH.
  - prog_en=0 -> IDLE; a partial word is discarded and len is unchanged.
  - start and stop are ignored.
- RUN:
  - sel_out=mem[step] and step_idx=step, registered; both update on the same edge that step changes.
  - dwell_cnt counts 0..dwell_latched; at terminal count step advances and dwell_cnt clears.
  - step==len-1 at terminal count -> step=0; wrap=1 for exactly that cycle (the cycle step_idx shows 0).
  - len=1: step stays 0 and wrap pulses every dwell+1 cycles.
  - stop=1 -> IDLE next edge: sel_out=0 (pass-through), step_idx=0, busy=0. stop beats the step advance on the same cycle.
  - prog_en, start and dwell are ignored in RUN.
- Datapath:
  - out_x[i] and out_y[i] are registered each cycle from the current data_a/data_b and the sel vector being applied on that same edge.
  - Latency from data inputs to outputs is 1 cycle.
  - In IDLE and LOAD, sel=0, so out_x=a and out_y=b.
- busy=1 exactly while state=RUN.
- Program memory is flops: DEPTH x NUM_CELLS, no read latency.

Decomposition:
- Shared package:
  - state enum (IDLE=0, LOAD=1, RUN=2);
  - default constants NUM_CELLS=4, DEPTH=8, DWELL_W=3;
  - function computing the step-index width.
- Sub-module cswap_cell: combinational 1-bit controlled swap with ports sel, a, b -> x, y. Instantiated NUM_CELLS times. The sequencer owns all registers.

Test Plan:
- Reset, then IDLE with data_a=4'b1010, data_b=4'b0101 -> next cycle out_x=1010, out_y=0101, sel_out=0, busy=0.
- Load words 4'b0001 and 4'b1111 (8 bits LSB first), then start with dwell=0 -> sel_out alternates 0001/1111 each cycle; wrap pulses each time step_idx returns to 0; with a=1010, b=0101, out_x alternates 1011/0101.
- Same program, dwell=2 -> each sel_out value held exactly 3 cycles; wrap period 6 cycles.
- Load 6 bits then drop prog_en -> len=1, only the first word is used; start gives constant sel_out=0001 and wrap every dwell+1 cycles.
- Load 9 words 1..9 -> len=8, mem[0]=9; RUN shows 9,2,3,...,8 then wraps.
- In RUN, assert stop and reset on separate occasions mid-dwell -> next edge busy=0, sel_out=0; start with len=0 after reset -> stays IDLE.
